// File: rtl/wbm_spi_tx_pkg.sv
// Shared constants and types for the SPI-slave transmit side of the
// Wishbone-master-over-SPI bridge.
package wbm_spi_tx_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // Byte shifted out when the Wishbone side has nothing ready.
  localparam byte_t IDLE_FILL = 8'h00;

  // Byte to load into the shift register at a boundary or while deselected.
  function automatic byte_t next_load(input logic pending, input byte_t pend_byte);
    return pending ? pend_byte : IDLE_FILL;
  endfunction

endpackage

// File: rtl/wbm_spi_tx_clock_domain_import.sv
// clock_domain_import: receiving half of a toggle handshake.
// Synchronises the remote toggle into clk, raises valid while the
// synchronised toggle differs from the local ack, and acknowledges
// (copies the synchronised toggle into handshake_local) once ready is seen.
//   clk              in   local clock
//   rst_n            in   asynchronous active-low reset
//   handshake_other  in   toggle from the sending domain
//   handshake_local  out  acknowledge toggle back to the sending domain
//   handshake_buffer in   data held stable by the sending domain
//   data             out  handshake_buffer, for capture while valid
//   ready            in   consumer can take the byte this edge
//   valid            out  a new byte is waiting
module clock_domain_import
  import wbm_spi_tx_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  handshake_other,
  output logic  handshake_local,
  input  byte_t handshake_buffer,
  output byte_t data,
  input  logic  ready,
  output logic  valid
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1           <= 1'b0;
      sync2           <= 1'b0;
      handshake_local <= 1'b0;
    end else begin
      sync1 <= handshake_other;
      sync2 <= sync1;
      if (valid && ready) begin
        handshake_local <= sync2;
      end
    end
  end

  assign valid = (sync2 != handshake_local);
  // The buffer is stable from the toggle until the ack, so no local copy is kept here.
  assign data  = handshake_buffer;

endmodule

// File: rtl/wbm_spi_tx.sv
// wbm_spi_tx: SPI-slave transmit half of the Wishbone-master-over-SPI bridge.
// Bytes arrive from the Wishbone domain via a toggle handshake, wait in a
// one-byte pending register, and are shifted out MSB-first on spi_sdo.
//   spi_sck          in   SPI clock, sole clock, posedge logic
//   rst_n            in   asynchronous active-low reset
//   spi_csn          in   chip select, active-low
//   spi_sdo          out  MISO, bit 7 of the shift register
//   handshake_wb     in   toggle: new byte in handshake_buffer
//   handshake_buffer in   byte to transmit
//   handshake_spi    out  acknowledge toggle
//   tx_underrun      out  one-cycle pulse: boundary reached with no byte pending
module wbm_spi_tx
  import wbm_spi_tx_pkg::*;
(
  input  logic       spi_sck,
  input  logic       rst_n,
  input  logic       spi_csn,
  output logic       spi_sdo,
  input  logic       handshake_wb,
  input  logic [7:0] handshake_buffer,
  output logic       handshake_spi,
  output logic       tx_underrun
);

  logic [2:0] bit_cnt;
  byte_t      shreg;
  logic       pending;
  byte_t      pend_byte;
  byte_t      imp_data;
  logic       imp_valid;
  logic       capture;
  logic       load;

  clock_domain_import u_import (
    .clk              (spi_sck),
    .rst_n            (rst_n),
    .handshake_other  (handshake_wb),
    .handshake_local  (handshake_spi),
    .handshake_buffer (handshake_buffer),
    .data             (imp_data),
    .ready            (!pending),
    .valid            (imp_valid)
  );

  // Capture only into an empty pending slot; a load only drains a full one,
  // so the two never act on the pending flag in the same edge.
  assign capture = imp_valid && !pending;
  assign load    = spi_csn || (bit_cnt == 3'd7);

  always_ff @(posedge spi_sck or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      shreg       <= IDLE_FILL;
      pending     <= 1'b0;
      pend_byte   <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;

      if (spi_csn) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (load) begin
        shreg <= next_load(pending, pend_byte);
        if (pending) begin
          pending <= 1'b0;
        end else if (!spi_csn) begin
          tx_underrun <= 1'b1;
        end
      end else begin
        shreg <= {shreg[BYTE_W-2:0], 1'b0};
      end

      if (capture) begin
        pending   <= 1'b1;
        pend_byte <= imp_data;
      end
    end
  end

  assign spi_sdo = shreg[BYTE_W-1];

endmodule

// File: tb/tb_wbm_spi_tx.sv
module tb_wbm_spi_tx;

  logic       spi_sck;
  logic       rst_n;
  logic       spi_csn;
  logic       spi_sdo;
  logic       handshake_wb;
  logic [7:0] handshake_buffer;
  logic       handshake_spi;
  logic       tx_underrun;

  int total;
  int bad;

  wbm_spi_tx dut (
    .spi_sck          (spi_sck),
    .rst_n            (rst_n),
    .spi_csn          (spi_csn),
    .spi_sdo          (spi_sdo),
    .handshake_wb     (handshake_wb),
    .handshake_buffer (handshake_buffer),
    .handshake_spi    (handshake_spi),
    .tx_underrun      (tx_underrun)
  );

  // One byte slot of an ongoing frame: expected byte on spi_sdo, whether
  // tx_underrun pulses at its closing boundary, and an optional byte to queue
  // before tick qpos (qpos >= 8 means nothing queued).
  typedef struct {
    logic [7:0] out;
    logic       und;
    int         qpos;
    logic [7:0] qb;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One SCK period; outputs are sampled afterwards, half a period past the rising edge.
  task automatic tick();
    #5 spi_sck = 1'b1;
    #5 spi_sck = 1'b0;
  endtask

  task automatic queue_byte(input logic [7:0] b);
    handshake_buffer = b;
    handshake_wb     = ~handshake_wb;
  endtask

  task automatic run_slot(input string nm, input vec_t v);
    for (int i = 0; i < 8; i++) begin
      if (i == v.qpos) queue_byte(v.qb);
      chk({nm, ".sdo"}, 8'(spi_sdo), 8'(v.out[7-i]));
      tick();
      chk({nm, ".undr"}, 8'(tx_underrun), 8'((i == 7) && v.und));
    end
    if (v.qpos < 8) chk({nm, ".ack"}, 8'(handshake_spi), 8'(handshake_wb));
  endtask

  // Deselected preload: toggle, then exactly 4 edges with csn high
  // (sync1, sync2, capture, load into the shift register).
  task automatic preload(input logic [7:0] b);
    spi_csn = 1'b1;
    queue_byte(b);
    repeat (4) tick();
  endtask

  initial begin
    vec_t v;
    logic [7:0] a5;
    total = 0;
    bad   = 0;
    a5    = 8'hA5;

    tbl[0] = '{out: 8'h3C, und: 1'b0, qpos: 0, qb: 8'hC3};
    tbl[1] = '{out: 8'hC3, und: 1'b0, qpos: 0, qb: 8'h81};
    tbl[2] = '{out: 8'h81, und: 1'b1, qpos: 8, qb: 8'h00};
    tbl[3] = '{out: 8'h00, und: 1'b0, qpos: 0, qb: 8'h5A};
    // Queued 3 edges before the boundary: captured on the boundary edge itself.
    tbl[4] = '{out: 8'h5A, und: 1'b1, qpos: 5, qb: 8'h66};
    tbl[5] = '{out: 8'h00, und: 1'b0, qpos: 8, qb: 8'h00};
    tbl[6] = '{out: 8'h66, und: 1'b1, qpos: 8, qb: 8'h00};

    spi_sck          = 1'b0;
    rst_n            = 1'b0;
    spi_csn          = 1'b1;
    handshake_wb     = 1'b0;
    handshake_buffer = 8'h00;

    #3;
    chk("rst.sdo", 8'(spi_sdo), 8'h00);
    chk("rst.ack", 8'(handshake_spi), 8'h00);
    chk("rst.undr", 8'(tx_underrun), 8'h00);
    #10 rst_n = 1'b1;

    // Single byte: ack on edge 3, loaded on edge 4, then 1,0,1,0,0,1,0,1.
    queue_byte(8'hA5);
    tick(); tick();
    chk("single.ack_e2", 8'(handshake_spi), 8'h00);
    tick();
    chk("single.ack_e3", 8'(handshake_spi), 8'h01);
    tick();
    spi_csn = 1'b0;
    v = '{out: 8'hA5, und: 1'b1, qpos: 8, qb: 8'h00};
    run_slot("single", v);

    // Continuous frame driven from the table.
    preload(8'h3C);
    spi_csn = 1'b0;
    for (int s = 0; s < 7; s++) begin
      run_slot($sformatf("slot%0d", s), tbl[s]);
    end

    // Backpressure: 0x55 arrives while 0x12 is still pending.
    preload(8'h99);
    spi_csn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) queue_byte(8'h12);
      if (i == 4) queue_byte(8'h55);
      chk("bp.a.sdo", 8'(spi_sdo), 8'(tbl[0].out[0] ^ tbl[0].out[0] ^ ((8'h99 >> (7 - i)) & 8'h01)));
      tick();
      if (i >= 6) chk("bp.held", 8'(handshake_spi == handshake_wb), 8'h00);
      chk("bp.a.undr", 8'(tx_underrun), 8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      chk("bp.b.sdo", 8'(spi_sdo), 8'((8'h12 >> (7 - i)) & 8'h01));
      tick();
      if (i == 0) chk("bp.ack_after", 8'(handshake_spi), 8'(handshake_wb));
      chk("bp.b.undr", 8'(tx_underrun), 8'h00);
    end
    v = '{out: 8'h55, und: 1'b1, qpos: 8, qb: 8'h00};
    run_slot("bp.c", v);

    // Abort after 3 bits of 0xF0 plus one deselected edge.
    preload(8'hF0);
    spi_csn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort.sdo", 8'(spi_sdo), 8'h01);
      tick();
    end
    queue_byte(8'h3A);
    spi_csn = 1'b1;
    tick();
    chk("abort.fill", 8'(spi_sdo), 8'h00);
    chk("abort.undr", 8'(tx_underrun), 8'h00);
    repeat (3) tick();
    spi_csn = 1'b0;
    v = '{out: 8'h3A, und: 1'b1, qpos: 8, qb: 8'h00};
    run_slot("abort.next", v);

    // Reset mid-frame with a byte pending and the ack toggled.
    preload(a5);
    queue_byte(8'h77);
    spi_csn = 1'b0;
    repeat (5) tick();
    chk("mid.sdo_pre", 8'(spi_sdo), 8'(a5[2]));
    chk("mid.ack_pre", 8'(handshake_spi), 8'(handshake_wb));
    rst_n        = 1'b0;
    handshake_wb = 1'b0;
    #1;
    chk("mid.rst.sdo", 8'(spi_sdo), 8'h00);
    chk("mid.rst.ack", 8'(handshake_spi), 8'h00);
    chk("mid.rst.undr", 8'(tx_underrun), 8'h00);
    #1 rst_n = 1'b1;
    v = '{out: 8'h00, und: 1'b1, qpos: 8, qb: 8'h00};
    run_slot("mid.next", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
